// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// performance-counter saturation limit.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFlush  = 2'd1,
    StFreeze = 2'd2
  } hz_state_e;

  localparam logic [15:0] CntMax = 16'hFFFF;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at its maximum instead of wrapping.
module sat_counter16
  import hazard_pkg::*;
(
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CntMax)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and
// data-memory freezes, with stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        IFID_UsesRt,
  input  logic        Jump,
  input  logic        BranchTaken,
  input  logic        DMemBusy,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        EXMEMWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  hz_state_e state_d, state_q;
  logic      load_use;

  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    EXMEMWrite = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    state_d    = state_q;
    if (Rst) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
      state_d    = StRun;
    end else if (DMemBusy) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
      state_d    = StFreeze;
    end else if (BranchTaken) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      state_d   = StFlush;
    end else if (state_q == StFlush) begin
      // Second bubble cycle of a taken branch; jump/load-use are squashed.
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      state_d   = StRun;
    end else if (Jump) begin
      IFIDFlush = 1'b1;
      state_d   = StRun;
    end else if (load_use) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
      state_d   = StRun;
    end else begin
      state_d = StRun;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter16 u_stall_cnt (
    .clk_i   (Clk),
    .clr_i   (Rst),
    .inc_i   (!PCWrite),
    .count_o (StallCount)
  );

  sat_counter16 u_flush_cnt (
    .clk_i   (Clk),
    .clr_i   (Rst),
    .inc_i   (IFIDFlush || IDEXFlush),
    .count_o (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, flushes, freezes, reset and saturation.
module tb_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        IFID_UsesRt;
  logic        Jump;
  logic        BranchTaken;
  logic        DMemBusy;
  logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush;
  logic [15:0] StallCount, FlushCount;

  int tests = 0;
  int fails = 0;

  hazard_ctrl dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_Rt      (IDEX_Rt),
    .IFID_Rs      (IFID_Rs),
    .IFID_Rt      (IFID_Rt),
    .IFID_UsesRt  (IFID_UsesRt),
    .Jump         (Jump),
    .BranchTaken  (BranchTaken),
    .DMemBusy     (DMemBusy),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IDEXWrite    (IDEXWrite),
    .EXMEMWrite   (EXMEMWrite),
    .IFIDFlush    (IFIDFlush),
    .IDEXFlush    (IDEXFlush),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed as {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush}.
  task automatic chk_out(input string tag, input logic [5:0] exp);
    chk(tag, {10'd0, PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush},
        {10'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] s, input logic [15:0] f);
    chk({tag, "_stall"}, StallCount, s);
    chk({tag, "_flush"}, FlushCount, f);
  endtask

  task automatic idle();
    IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
    IFID_UsesRt = 1'b0; Jump = 1'b0; BranchTaken = 1'b0; DMemBusy = 1'b0;
  endtask

  task automatic nxt();
    @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b1;
    idle();
    #1;
    chk_out("rst_outs", 6'b000011);
    nxt(); #1;
    chk_out("rst_outs2", 6'b000011);
    chk_cnt("rst_cnt", 16'd0, 16'd0);

    nxt(); Rst = 1'b0; #1;
    chk_out("idle", 6'b111100);
    chk_cnt("idle_cnt", 16'd0, 16'd0);

    // $zero is never a hazard
    nxt(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; #1;
    chk_out("zero_exempt", 6'b111100);
    nxt(); IDEX_Rt = 5'd7; IFID_Rs = 5'd3; IFID_Rt = 5'd7; IFID_UsesRt = 1'b0; #1;
    chk_out("rt_unused", 6'b111100);
    chk_cnt("zero_cnt", 16'd0, 16'd0);
    nxt(); IFID_UsesRt = 1'b1; #1;
    chk_out("rt_used", 6'b001101);

    nxt(); idle(); #1;
    chk_cnt("rt_cnt", 16'd1, 16'd1);
    nxt(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5; #1;
    chk_out("load_use", 6'b001101);
    nxt(); idle(); #1;
    chk_out("after_lu", 6'b111100);
    chk_cnt("lu_cnt", 16'd2, 16'd2);

    nxt(); Jump = 1'b1; #1;
    chk_out("jump", 6'b111110);
    nxt(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5; #1;
    chk_out("jump_over_lu", 6'b111110);
    nxt(); idle(); #1;
    chk_cnt("jump_cnt", 16'd2, 16'd4);

    nxt(); BranchTaken = 1'b1; #1;
    chk_out("br_c1", 6'b111111);
    nxt(); BranchTaken = 1'b0; #1;
    chk_out("br_c2", 6'b111111);
    nxt(); #1;
    chk_out("br_done", 6'b111100);
    chk_cnt("br_cnt", 16'd2, 16'd6);

    // Re-branch in FLUSH restarts it; jump/load-use stay squashed
    nxt(); BranchTaken = 1'b1; #1;
    chk_out("rebr_c1", 6'b111111);
    nxt(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5; #1;
    chk_out("rebr_c2", 6'b111111);
    nxt(); BranchTaken = 1'b0; IDEX_MemRead = 1'b0; Jump = 1'b1; #1;
    chk_out("rebr_c3", 6'b111111);
    nxt(); idle(); #1;
    chk_out("rebr_done", 6'b111100);
    chk_cnt("rebr_cnt", 16'd2, 16'd9);

    nxt(); DMemBusy = 1'b1; #1;
    chk_out("frz_c1", 6'b000000);
    nxt(); BranchTaken = 1'b1; #1;
    chk_out("frz_c2", 6'b000000);
    nxt(); BranchTaken = 1'b0; #1;
    chk_out("frz_c3", 6'b000000);
    nxt(); DMemBusy = 1'b0; #1;
    chk_out("frz_exit", 6'b111100);
    chk_cnt("frz_cnt", 16'd5, 16'd9);

    nxt(); DMemBusy = 1'b1; BranchTaken = 1'b1; #1;
    chk_out("frz_br", 6'b000000);
    nxt(); DMemBusy = 1'b0; #1;
    chk_out("frz_br_go", 6'b111111);
    nxt(); BranchTaken = 1'b0; #1;
    chk_out("frz_br_c2", 6'b111111);
    nxt(); #1;
    chk_out("frz_br_done", 6'b111100);
    chk_cnt("frz_br_cnt", 16'd6, 16'd11);

    nxt(); BranchTaken = 1'b1; #1;
    chk_out("rstfl_c1", 6'b111111);
    nxt(); BranchTaken = 1'b0; Rst = 1'b1; #1;
    chk_out("rstfl_rst", 6'b000011);
    nxt(); Rst = 1'b0; #1;
    chk_out("rstfl_rel", 6'b111100);
    chk_cnt("rstfl_cnt", 16'd0, 16'd0);

    nxt(); DMemBusy = 1'b1;
    repeat (69999) nxt();
    nxt(); #1;
    chk_cnt("sat", 16'hFFFF, 16'd0);
    nxt(); #1;
    chk_cnt("sat_hold", 16'hFFFF, 16'd0);
    nxt(); DMemBusy = 1'b0; #1;
    chk_out("sat_exit", 6'b111100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
